// File: rtl/adder_pkg.sv
// Shared types and configuration checks for the pipelined adder.
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_ADC = 2'd1,
        OP_SUB = 2'd2
    } adder_op_t;

    // Legal configuration: positive chunk, at least one stage, width an exact multiple of chunk.
    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; msb_cIn is the carry into the top bit, used for signed overflow.
module adder_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cIn,
    output logic [CHUNK-1:0] s,
    output logic             cOut,
    output logic             msb_cIn
);

    // Bit-serial ripple through the slice, capturing the carry that enters the MSB.
    always_comb begin
        logic c;
        s       = '0;
        msb_cIn = 1'b0;
        c       = cIn;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) msb_cIn = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cOut = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one CHUNK slice resolved per stage, carry registered between stages,
// valid/ready on both sides with a global stall (no skid buffer).
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  adder_op_t        op,
    input  logic             cIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int STAGES = WIDTH / CHUNK;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Per-stage payload: operands still to be resolved, partial sum, carry into the next slice,
    // and the carry into the MSB of the slice just resolved.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             msb_c;
    } stage_t;

    logic              stall;
    logic              take;
    logic [STAGES:1]   vld_pipe;
    stage_t            cond;

    assign out_valid = vld_pipe[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign take      = in_valid & in_ready;

    // Operand conditioning: subtract is a + ~b + 1; reserved op code behaves as plain add.
    always_comb begin
        cond   = '0;
        cond.a = a;
        case (op)
            OP_ADC:  begin cond.b = b;  cond.c = cIn;  end
            OP_SUB:  begin cond.b = ~b; cond.c = 1'b1; end
            default: begin cond.b = b;  cond.c = 1'b0; end
        endcase
    end

    // Valid shift register; whole pipe freezes on stall, bubbles included.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[1] <= take;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        stage_t           src;
        stage_t           nxt;
        stage_t           q;
        logic [CHUNK-1:0] cs;
        logic             co;
        logic             mc;

        if (k == 0) begin : g_first
            assign src = cond;
        end else begin : g_rest
            assign src = g_stg[k-1].q;
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a       (src.a[k*CHUNK +: CHUNK]),
            .b       (src.b[k*CHUNK +: CHUNK]),
            .cIn     (src.c),
            .s       (cs),
            .cOut    (co),
            .msb_cIn (mc)
        );

        // Splice this stage's slice into the travelling partial sum.
        always_comb begin
            nxt                       = src;
            nxt.s[k*CHUNK +: CHUNK]   = cs;
            nxt.c                     = co;
            nxt.msb_c                 = mc;
        end

        // Stage register: cleared by reset, held while stalled.
        always_ff @(posedge clk) begin
            if (reset)       q <= '0;
            else if (!stall) q <= nxt;
        end
    end

    assign sum      = g_stg[STAGES-1].q.s;
    assign cOut     = g_stg[STAGES-1].q.c;
    assign overflow = g_stg[STAGES-1].q.c ^ g_stg[STAGES-1].q.msb_c;
    // Gated by valid so the cleared register after reset does not report zero.
    assign zero     = out_valid & ~|sum;
    assign negative = sum[WIDTH-1];

    // Operands are fully consumed by the last stage.
    logic unused_ok;
    assign unused_ok = ^{g_stg[STAGES-1].q.a, g_stg[STAGES-1].q.b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=64, CHUNK=16).
module tb_pipelined_adder;
    import adder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    adder_op_t   op = OP_ADD;
    logic        cIn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] sum;
    logic        cOut, overflow, zero, negative;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cIn(cIn), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cOut(cOut), .overflow(overflow), .zero(zero), .negative(negative)
    );

    typedef struct {
        logic [63:0] sum;
        logic        co, ov, z, n;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stalls = 0;
    bit   rnd_rdy = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    // Reference: whole-word arithmetic; overflow from a sign-extended wider sum.
    function automatic exp_t model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci);
        exp_t        e;
        logic [64:0] u;
        logic [65:0] sx, sy, s;
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        case (o)
            2'd2: begin
                e.sum = x - y;
                e.co  = (x >= y);
                s     = sx - sy;
            end
            2'd1: begin
                u     = {1'b0, x} + {1'b0, y} + 65'(ci);
                e.sum = u[63:0];
                e.co  = u[64];
                s     = sx + sy + 66'(ci);
            end
            default: begin
                u     = {1'b0, x} + {1'b0, y};
                e.sum = u[63:0];
                e.co  = u[64];
                s     = sx + sy;
            end
        endcase
        e.ov  = s[64] ^ s[63];
        e.z   = (e.sum == 64'd0);
        e.n   = e.sum[63];
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic ci);
        bit   acc;
        int   guard;
        exp_t e;
        acc      = 0;
        guard    = 0;
        op       = adder_op_t'(o);
        a        = x;
        b        = y;
        cIn      = ci;
        in_valid = 1'b1;
        while (!acc && guard < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc   = 1;
                e     = model(o, x, y, ci);
                e.cyc = cyc;
                e.stl = stalls;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string nm, input logic [63:0] want);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk(nm, sum, want);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: retire results against the scoreboard, check stall behaviour.
    initial begin
        bit          held_v;
        logic [63:0] held_sum;
        logic [3:0]  held_f;
        exp_t        e;
        held_v = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_sum", sum, held_sum);
                    chk("hold_flags", 64'({cOut, overflow, zero, negative}), 64'(held_f));
                end
                held_v = 0;
                if (out_valid && !out_ready) begin
                    stalls++;
                    chk("in_ready_stall", 64'(in_ready), 64'd0);
                    held_v   = 1;
                    held_sum = sum;
                    held_f   = {cOut, overflow, zero, negative};
                end else if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result got=%h want=none", sum);
                    end else begin
                        e = q.pop_front();
                        chk("sum", sum, e.sum);
                        chk("cout", 64'(cOut), 64'(e.co));
                        chk("overflow", 64'(overflow), 64'(e.ov));
                        chk("zero", 64'(zero), 64'(e.z));
                        chk("negative", 64'(negative), 64'(e.n));
                        chk("latency", 64'(cyc - e.cyc), 64'(4 + stalls - e.stl));
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_flags", 64'({cOut, overflow, zero, negative}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        issue(2'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        wait_out("carry_chain", 64'h0000_0001_0000_0000);
        drain();

        issue(2'd2, 64'd5, 64'd5, 1'b0);
        issue(2'd2, 64'd3, 64'd5, 1'b0);
        issue(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        issue(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        issue(2'd3, 64'd10, 64'd20, 1'b1);
        issue(2'd0, 64'd1, 64'd1, 1'b1);
        issue(2'd2, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        drain();

        // Back-to-back with a 3-cycle output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        rnd_rdy   = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Reset with three operations in flight: all discarded.
        issue(2'd0, 64'd100, 64'd1, 1'b0);
        issue(2'd0, 64'd200, 64'd2, 1'b0);
        issue(2'd0, 64'd300, 64'd3, 1'b0);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_sum", sum, 64'd0);
        chk("flush_flags", 64'({cOut, overflow, zero, negative}), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("flush_no_ghost", 64'(seen), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(2'd0, 64'd2, 64'd2, 1'b0);
        wait_out("post_reset", 64'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
